valid_data_delay_line: RTL and testbench

- Fixed-latency delay line for a data bus plus its valid qualifier.
- Every input beat appears at the output exactly `depth` clock cycles later, together with its valid flag.
- Used to align side-band data and valid with multi-stage arithmetic pipelines, for example a pipelined sqrt/formula datapath.
- Only the valid chain is reset. The data chain is reset-free to save area and fanout.

---
 rtl/valid_data_delay_line_if.sv | 31 +++
 rtl/valid_data_delay_line.sv | 70 +++++++
 tb/tb_valid_data_delay_line.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/valid_data_delay_line_if.sv
// -----------------------------------------------------------------------------
// valid_data_delay_line_if
//   Groups the beat bus of the valid/data delay line.
//   in_vld / in_data   : beat entering the delay line (driven by the producer)
//   out_vld / out_data : beat leaving the delay line (driven by the delay line)
//   Modports:
//     master - producer/consumer side (drives in_*, observes out_*)
//     slave  - delay line side (observes in_*, drives out_*)
// -----------------------------------------------------------------------------
interface valid_data_delay_line_if #(
  parameter int width = 8
);
  logic             in_vld;
  logic [width-1:0] in_data;
  logic             out_vld;
  logic [width-1:0] out_data;

  modport master (
    output in_vld,
    output in_data,
    input  out_vld,
    input  out_data
  );

  modport slave (
    input  in_vld,
    input  in_data,
    output out_vld,
    output out_data
  );
endinterface

// File: rtl/valid_data_delay_line.sv
// -----------------------------------------------------------------------------
// valid_data_delay_line
//   Fixed-latency delay line for a payload bus and its valid qualifier. Every
//   beat presented on bus.in_* reappears on bus.out_* exactly `depth` clock
//   edges later. Used to keep side-band data aligned with multi-stage
//   arithmetic pipelines.
//
//   Parameters:
//     width - payload width in bits (>= 1)
//     depth - latency in clock cycles / number of register stages (>= 1)
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - asynchronous active-low reset (0 = reset); clears the valid chain
//     bus  - slave side of valid_data_delay_line_if
//              in_vld/in_data   : input beat
//              out_vld/out_data : beat delayed by depth cycles (registered)
//
//   Only the valid chain is reset. The data chain shifts every clock, even
//   during reset, and is never qualified by valid; downstream logic must look
//   at out_vld before using out_data.
// -----------------------------------------------------------------------------
module valid_data_delay_line #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  valid_data_delay_line_if.slave  bus
);

  genvar gi;

  // One generate block per stage; each stage owns its own registers so that
  // every flop has exactly one driving process.
  for (gi = 0; gi < depth; gi++) begin : g_stage
    logic             w_vld_src;
    logic [width-1:0] w_data_src;
    logic             r_vld;
    logic [width-1:0] r_data;

    if (gi == 0) begin : g_head
      assign w_vld_src  = bus.in_vld;
      assign w_data_src = bus.in_data;
    end else begin : g_link
      assign w_vld_src  = g_stage[gi-1].r_vld;
      assign w_data_src = g_stage[gi-1].r_data;
    end

    // Valid stage: asynchronous clear so out_vld drops the moment reset is
    // asserted and never carries X once reset has been applied.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_vld <= 1'b0;
      end else begin
        r_vld <= w_vld_src;
      end
    end

    // Data stage: no reset and no enable, keeping the wide chain free of
    // reset fanout.
    always_ff @(posedge clk) begin
      r_data <= w_data_src;
    end
  end

  assign bus.out_vld  = g_stage[depth-1].r_vld;
  assign bus.out_data = g_stage[depth-1].r_data;

endmodule

// File: tb/tb_valid_data_delay_line.sv
// -----------------------------------------------------------------------------
// tb_valid_data_delay_line
//   Scoreboard bench for valid_data_delay_line (width=8, depth=8).
//   The driver records every valid beat it issues, tagged with the edge count
//   at which it must emerge; reset discards everything recorded so far. An
//   independent monitor checks out_vld/out_data on every falling edge.
// -----------------------------------------------------------------------------
module tb_valid_data_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  typedef struct {
    int               due;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   edge_cnt;
  int   n_cmp;
  int   n_bad;
  bit   mon_en;
  exp_t exp_q[$];
  exp_t head;
  logic exp_vld;

  valid_data_delay_line_if #(.width(WIDTH)) bus ();

  valid_data_delay_line #(
    .width (WIDTH),
    .depth (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: a beat driven at falling edge E (sampled at rising edge E+1)
  // must appear at falling edge E+DEPTH.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_vld = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
      n_cmp++;
      if (bus.out_vld !== exp_vld) begin
        n_bad++;
        $display("FAIL out_vld edge %0d: got %b expected %b", edge_cnt, bus.out_vld, exp_vld);
      end
      if (exp_vld) begin
        head = exp_q.pop_front();
        n_cmp++;
        if (bus.out_data !== head.data) begin
          n_bad++;
          $display("FAIL out_data edge %0d: got %h expected %h", edge_cnt, bus.out_data, head.data);
        end else begin
          $display("beat out edge %0d data %h", edge_cnt, bus.out_data);
        end
      end
    end
  end

  // Drive one beat at the current falling edge, then advance to the next one.
  task automatic beat(input logic v, input logic [WIDTH-1:0] d);
    exp_t e;
    bus.in_vld  = v;
    bus.in_data = d;
    if (v && rst === 1'b1) begin
      e.due  = edge_cnt + DEPTH;
      e.data = d;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, WIDTH'($urandom));
  endtask

  // Assert reset between edges, confirm out_vld clears without a clock,
  // hold for n cycles and release on a falling edge.
  task automatic do_reset(input int n);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (bus.out_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset time %0t: out_vld got %b expected 0", $time, bus.out_vld);
    end
    mon_en = 1'b1;
    repeat (n) @(negedge clk);
    rst         = 1'b1;
    bus.in_vld  = 1'b0;
  endtask

  logic       sp_vld [7];
  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    mon_en = 1'b0;
    rst          = 1'bx;
    bus.in_vld   = 1'bx;
    bus.in_data  = 'x;

    // Unknown reset and valid before reset is ever applied.
    repeat (3) @(negedge clk);
    do_reset(3);

    // Single beat.
    beat(1'b1, 8'hA5);
    idle(DEPTH + 3);

    // Back-to-back stream 01..10.
    for (int i = 1; i <= 16; i++) beat(1'b1, WIDTH'(i));
    idle(DEPTH + 2);

    // Sparse pattern.
    sp_vld = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) beat(sp_vld[i], WIDTH'(8'h11 + i));
    idle(DEPTH + 2);

    // Reset with a full pipe in flight: nothing from before must emerge.
    for (int i = 0; i < DEPTH + 1; i++) beat(1'b1, WIDTH'(8'h40 + i));
    do_reset(2);
    idle(DEPTH + 4);

    // Randomized regression.
    for (int r = 0; r < 24; r++) begin
      do_reset(1 + int'($urandom_range(2)));
      for (int i = 0; i < 24; i++) beat(1'($urandom), WIDTH'($urandom));
    end
    idle(DEPTH + 2);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending beats got %0d expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
